// File: rtl/uart_reg_host_if.sv
// Request/response handshake plus uart_core byte channel of the UART register host.
interface uart_reg_host_if #(
  parameter int W_REG  = 32,
  parameter int N_REGS = 8
);
  localparam int ADDR_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [W_REG-1:0]  req_wdata;
  logic              rsp_valid;
  logic [W_REG-1:0]  rsp_rdata;
  logic              rsp_err;
  logic [7:0]        tx_byte;
  logic              tx_valid;
  logic              tx_done;
  logic [7:0]        rx_byte;
  logic              rx_valid;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, tx_done, rx_byte, rx_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, tx_byte, tx_valid
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, tx_done, rx_byte, rx_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, tx_byte, tx_valid
  );
endinterface

// File: rtl/uart_reg_host.sv
// Host-side initiator: turns register read/write requests into UART command frames
// and collects the ACK byte or read data, with an inter-byte response timeout.
module uart_reg_host #(
  parameter int         W_REG    = 32,
  parameter int         N_REGS   = 8,
  parameter int         TIMEOUT  = 65535,
  parameter logic [7:0] ACK_BYTE = 8'hA5
) (
  input  logic           clk,
  input  logic           rst,
  uart_reg_host_if.slave bus
);
  localparam int N_BYTES = W_REG / 8;
  localparam int ADDR_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int BW      = $clog2(N_BYTES + 1);
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(N_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_CMD  = 3'd1,
    SEND_DATA = 3'd2,
    WAIT_ACK  = 3'd3,
    RECV_DATA = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t           state_r;
  logic             write_r;
  logic [W_REG-1:0] wdata_r;
  logic [BW-1:0]    idx_r;
  logic [TW-1:0]    timer_r;
  logic             req_ready_r;
  logic             rsp_valid_r;
  logic             rsp_err_r;
  logic [W_REG-1:0] rsp_rdata_r;
  logic             tx_valid_r;
  logic [7:0]       tx_byte_r;
  logic [7:0]       cmd_s;

  function automatic logic [7:0] byte_of(input logic [W_REG-1:0] word, input logic [BW-1:0] idx);
    return 8'(word >> {idx, 3'b000});
  endfunction

  // Command byte: R/W flag in bit 7, register index in the low bits.
  always_comb begin
    cmd_s              = 8'h00;
    cmd_s[7]           = bus.req_write;
    cmd_s[ADDR_W-1:0]  = bus.req_addr;
  end

  // Frame sequencer; the timer measures idle cycles since entry or the last accepted byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      write_r     <= 1'b0;
      wdata_r     <= '0;
      idx_r       <= '0;
      timer_r     <= '0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= '0;
      tx_valid_r  <= 1'b0;
      tx_byte_r   <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            write_r     <= bus.req_write;
            wdata_r     <= bus.req_wdata;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            tx_byte_r   <= cmd_s;
            tx_valid_r  <= 1'b1;
            req_ready_r <= 1'b0;
            state_r     <= SEND_CMD;
          end
        end
        SEND_CMD: begin
          if (tx_valid_r && bus.tx_done) begin
            tx_valid_r <= 1'b0;
            idx_r      <= '0;
            timer_r    <= '0;
            if (write_r) begin
              tx_byte_r <= byte_of(wdata_r, BW'(0));
              state_r   <= SEND_DATA;
            end else begin
              tx_byte_r <= 8'h00;
              state_r   <= RECV_DATA;
            end
          end
        end
        SEND_DATA: begin
          // One cycle with tx_valid low separates consecutive bytes.
          if (!tx_valid_r) begin
            tx_valid_r <= 1'b1;
          end else if (bus.tx_done) begin
            tx_valid_r <= 1'b0;
            if (idx_r == LAST_IDX) begin
              tx_byte_r <= 8'h00;
              idx_r     <= '0;
              timer_r   <= '0;
              state_r   <= WAIT_ACK;
            end else begin
              tx_byte_r <= byte_of(wdata_r, idx_r + BW'(1));
              idx_r     <= idx_r + BW'(1);
            end
          end
        end
        WAIT_ACK: begin
          if (bus.rx_valid) begin
            rsp_err_r   <= (bus.rx_byte != ACK_BYTE);
            rsp_valid_r <= 1'b1;
            timer_r     <= '0;
            state_r     <= RESP;
          end else if (timer_r == TMO_LAST) begin
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        RECV_DATA: begin
          if (bus.rx_valid) begin
            for (int k = 0; k < N_BYTES; k++) begin
              if (idx_r == BW'(k)) begin
                rsp_rdata_r[8*k +: 8] <= bus.rx_byte;
              end
            end
            timer_r <= '0;
            if (idx_r == LAST_IDX) begin
              idx_r       <= '0;
              rsp_err_r   <= 1'b0;
              rsp_valid_r <= 1'b1;
              state_r     <= RESP;
            end else begin
              idx_r <= idx_r + BW'(1);
            end
          end else if (timer_r == TMO_LAST) begin
            // Partial read data is kept; bytes never received stay zero.
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        RESP: begin
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          tx_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.tx_valid  = tx_valid_r;
  assign bus.tx_byte   = tx_byte_r;
endmodule

// File: doc/uart_reg_host.md
Name: uart_reg_host

Overview:
Host-side initiator for the UART register-access protocol served by the register-file responder. Converts parallel read/write requests into command byte sequences on a uart_core byte interface. Collects the responder's ACK byte or read data, and returns one response per request. Includes a response timeout.

Parameters:
W_REG, 32, register width in bits; must be a multiple of 8; N_BYTES = W_REG/8
N_REGS, 8, number of addressable registers; ADDR_W = $clog2(N_REGS), max 7 bits
TIMEOUT, 65535, idle cycles allowed between response bytes before abort
ACK_BYTE, 8'hA5, byte the responder returns after a completed write

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block accepts a request; high only in IDLE
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  register index
req_wdata  input  W_REG  write data
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  W_REG  read data; 0 for writes
rsp_err  output  1  valid with rsp_valid; 1 = timeout or bad ACK
tx_byte  output  8  byte to uart_core transmitter
tx_valid  output  1  tx_byte valid; held until tx_done
tx_done  input  1  one-cycle pulse: uart_core finished sending tx_byte
rx_byte  input  8  byte from uart_core receiver
rx_valid  input  1  one-cycle pulse: rx_byte valid

Behaviour:
- Frame format:
  - command byte = {req_write, zero pad, req_addr} (bit 7 = R/W, addr in LSBs)
  - write: command, then N_BYTES data bytes LSB first; responder returns ACK_BYTE
  - read: command only; responder returns N_BYTES bytes LSB first
- Reset: state=IDLE; req_ready=1; tx_valid=0; tx_byte=0; rsp_valid=0; rsp_err=0; rsp_rdata=0; byte counter and timeout counter cleared.
- Reset mid-frame: abort immediately, no response, tx_valid drops the next cycle.
- States:
  - IDLE: req_ready=1. On req_valid: capture write/addr/wdata, go to SEND_CMD. Request accepted same cycle, req_ready low next cycle.
  - SEND_CMD: tx_valid=1, tx_byte=command. On tx_done: write -> SEND_DATA with byte index 0; read -> RECV_DATA.
  - SEND_DATA: tx_byte = wdata[8*i+7:8*i]. On tx_done: i++. After byte N_BYTES-1 -> WAIT_ACK.
  - WAIT_ACK: first rx_valid -> RESP, rsp_err = (rx_byte != ACK_BYTE).
  - RECV_DATA: each rx_valid stores rx_byte at byte index i (LSB first). After N_BYTES bytes -> RESP with err=0.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready returns high in the following cycle.
- TX handshake:
  - tx_valid goes high on entry to a send state; tx_byte is stable while tx_valid=1.
  - The cycle tx_done is seen, tx_valid is still 1. Next byte (or 0) is presented from the following cycle.
  - tx_valid deasserts one cycle in every inter-byte gap.
  - tx_done while tx_valid=0 is ignored.
- rx_valid outside WAIT_ACK/RECV_DATA is discarded: stale bytes are flushed and do not count.
- Timeout:
  - Counter runs only in WAIT_ACK/RECV_DATA; clears on state entry and on every accepted rx_valid.
  - Reaching TIMEOUT -> RESP with rsp_err=1. rsp_rdata holds the bytes received so far; unreceived bytes are 0.
  - rx_valid in the same cycle the counter reaches TIMEOUT: the byte wins, counter clears.
- rsp_rdata is cleared at request accept. Write responses always return rsp_rdata=0.
- Latency:
  - Request accept to tx_valid: 1 cycle.
  - Final byte rx_valid to rsp_valid: 1 cycle.

Test Plan:
- Write addr=3, wdata=32'hDEADBEEF; model returns tx_done 10 cycles after each tx_valid, then rx 8'hA5 -> tx sequence 8'h83,EF,BE,AD,DE; one rsp_valid with rsp_err=0, rsp_rdata=0.
- Read addr=5; model returns rx 8'h78,56,34,12 -> tx 8'h05 only; rsp_rdata=32'h12345678, rsp_err=0; req_ready low from accept until the cycle after rsp_valid.
- Write with responder returning 8'h5A -> rsp_err=1 after that byte; next request accepted normally.
- Read, TIMEOUT=100, only 2 bytes 8'h11,8'h22 returned -> rsp_valid 100 cycles after the last byte; rsp_err=1, rsp_rdata=32'h00002211.
- Stray rx_valid 8'hFF in IDLE, then read returning 8'h01,02,03,04 -> rsp_rdata=32'h04030201; the stray byte is ignored.
- rst asserted during SEND_DATA byte 2 -> tx_valid=0 next cycle, no rsp_valid, req_ready=1; a new read then completes correctly.
